// File: rtl/ex_muldiv_ctrl_pkg.sv
// riscv_muldiv_pkg: shared encodings and decode helpers for the RV32M
// multiply/divide sequencer (op codes, FSM state codes, operand decode).
package riscv_muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic is_div(input logic [2:0] op);
        case (op)
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    // Quotient-producing divide ops; the other divide ops return the remainder.
    function automatic logic is_quotient(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Multiply ops that return the upper half of the double-width product.
    function automatic logic is_mul_high(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_iter.sv
// muldiv_iter: shared shift-add multiply / restoring divide datapath.
// Multiply: {hi,lo} holds partial product with the multiplier shifting out of lo.
// Divide:   hi holds the partial remainder, lo shifts the dividend out and the
//           quotient in. One BIT_W+1-bit adder serves both modes.
module muldiv_iter
    import riscv_muldiv_pkg::*;
#(
    parameter int BIT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step_en,
    input  logic             div_mode,
    input  logic [BIT_W-1:0] a_mag,
    input  logic [BIT_W-1:0] b_mag,
    output logic [BIT_W-1:0] hi_nxt,
    output logic [BIT_W-1:0] lo_nxt
);

    logic [BIT_W-1:0] hi;
    logic [BIT_W-1:0] lo;
    logic [BIT_W-1:0] divisor;
    logic [BIT_W:0]   shifted;
    logic [BIT_W:0]   add_x;
    logic [BIT_W:0]   add_y;
    logic [BIT_W:0]   sum;
    logic             fits;

    // One iteration: add multiplicand or trial-subtract divisor, then shift.
    always_comb begin
        shifted = {hi, lo[BIT_W-1]};
        if (div_mode) begin
            add_x = shifted;
            add_y = ~{1'b0, divisor};
        end else begin
            add_x = {1'b0, hi};
            add_y = lo[0] ? {1'b0, divisor} : '0;
        end
        sum  = add_x + add_y + {{BIT_W{1'b0}}, div_mode};
        fits = ~sum[BIT_W];
        if (div_mode) begin
            hi_nxt = fits ? sum[BIT_W-1:0] : shifted[BIT_W-1:0];
            lo_nxt = {lo[BIT_W-2:0], fits};
        end else begin
            hi_nxt = sum[BIT_W:1];
            lo_nxt = {sum[0], lo[BIT_W-1:1]};
        end
    end

    // Operand registers: load on start, advance once per enabled step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi      <= '0;
            lo      <= '0;
            divisor <= '0;
        end else if (load) begin
            hi      <= '0;
            lo      <= a_mag;
            divisor <= b_mag;
        end else if (step_en) begin
            hi <= hi_nxt;
            lo <= lo_nxt;
        end
    end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: EX-stage RV32M sequencer. Owns the FSM, iteration counter,
// sign handling and RISC-V special cases around the muldiv_iter datapath.
// Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and
// multiply-by-zero skip CALC and finish one cycle after start.
module ex_muldiv_ctrl
    import riscv_muldiv_pkg::*;
#(
    parameter int BIT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [2:0]       op,
    input  logic [BIT_W-1:0] rs1_dat,
    input  logic [BIT_W-1:0] rs2_dat,
    input  logic             flush,
    output logic             stall_req,
    output logic             busy,
    output logic [BIT_W-1:0] result,
    output logic             result_valid
);

    localparam int CNT_W = $clog2(BIT_W);
    localparam logic [BIT_W-1:0] MIN_NEG = {1'b1, {(BIT_W-1){1'b0}}};

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] count;
    logic [2:0]       op_q;
    logic             a_neg_q;
    logic             b_neg_q;
    logic             div_zero_q;
    logic             ovf_q;
    logic [BIT_W-1:0] rs1_q;
    logic             start;
    logic             last;
    logic             a_neg;
    logic             b_neg;
    logic             div_zero;
    logic             ovf;
    logic             early;
    logic [BIT_W-1:0] a_mag;
    logic [BIT_W-1:0] b_mag;
    logic [BIT_W-1:0] hi_nxt;
    logic [BIT_W-1:0] lo_nxt;

    // Apply operand signs and the mandated divide special cases to magnitudes.
    function automatic logic [BIT_W-1:0] fix_up(
        input logic [2:0]       f_op,
        input logic             f_a_neg,
        input logic             f_b_neg,
        input logic             f_dz,
        input logic             f_ovf,
        input logic [BIT_W-1:0] f_rs1,
        input logic [BIT_W-1:0] f_hi,
        input logic [BIT_W-1:0] f_lo
    );
        logic [2*BIT_W-1:0] prod;
        logic [BIT_W-1:0]   val;
        prod = {f_hi, f_lo};
        if (f_a_neg ^ f_b_neg)
            prod = -prod;
        val = is_mul_high(f_op) ? prod[2*BIT_W-1:BIT_W] : prod[BIT_W-1:0];
        if (is_div(f_op)) begin
            if (is_quotient(f_op)) begin
                if (f_dz)       val = '1;
                else if (f_ovf) val = f_rs1;
                else            val = (f_a_neg ^ f_b_neg) ? -f_lo : f_lo;
            end else begin
                if (f_dz)       val = f_rs1;
                else if (f_ovf) val = '0;
                else            val = f_a_neg ? -f_hi : f_hi;
            end
        end
        return val;
    endfunction

    // Decode the instruction presented by ID/EX and detect special cases.
    always_comb begin
        start    = (state == ST_IDLE) && valid_in && !flush;
        last     = (state == ST_CALC) && (count == CNT_W'(BIT_W - 1));
        a_neg    = is_signed_a(op) && rs1_dat[BIT_W-1];
        b_neg    = is_signed_b(op) && rs2_dat[BIT_W-1];
        a_mag    = a_neg ? -rs1_dat : rs1_dat;
        b_mag    = b_neg ? -rs2_dat : rs2_dat;
        div_zero = is_div(op) && (rs2_dat == '0);
        ovf      = is_div(op) && is_signed_b(op) && (rs1_dat == MIN_NEG) && (rs2_dat == '1);
`ifdef MULDIV_EARLY_OUT_EN
        early    = div_zero || ovf || (!is_div(op) && ((rs1_dat == '0) || (rs2_dat == '0)));
`else
        early    = 1'b0;
`endif
    end

    // FSM next state; a flush always returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = early ? ST_DONE : ST_CALC;
            ST_CALC: if (last)  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (flush)
            state_nxt = ST_IDLE;
    end

    // State, operand flags, counter and the registered result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            count      <= '0;
            op_q       <= OP_MUL;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            rs1_q      <= '0;
            result     <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                count      <= '0;
                op_q       <= op;
                a_neg_q    <= a_neg;
                b_neg_q    <= b_neg;
                div_zero_q <= div_zero;
                ovf_q      <= ovf;
                rs1_q      <= rs1_dat;
            end else if (state == ST_CALC) begin
                count <= count + CNT_W'(1);
            end
            if (last && !flush)
                result <= fix_up(op_q, a_neg_q, b_neg_q, div_zero_q, ovf_q, rs1_q, hi_nxt, lo_nxt);
            else if (start && early)
                result <= fix_up(op, a_neg, b_neg, div_zero, ovf, rs1_dat, '0, '0);
        end
    end

    assign stall_req    = rst_n && !flush && (((state == ST_IDLE) && valid_in) || (state == ST_CALC));
    assign result_valid = rst_n && !flush && (state == ST_DONE);
    assign busy         = (state != ST_IDLE);

    muldiv_iter #(
        .BIT_W (BIT_W)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start),
        .step_en  (state == ST_CALC),
        .div_mode (is_div(op_q)),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .hi_nxt   (hi_nxt),
        .lo_nxt   (lo_nxt)
    );

endmodule
